// File: rtl/iter_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iter_alu
// Purpose  : Execution-stage ALU with a registered result. ADD, SUB, AND,
//            XOR, SLL and SRAI complete in one cycle. MUL runs as a
//            shift-add loop over WIDTH cycles. ready_o/valid_o let the hazard
//            unit stall the pipeline while a multiply is in flight.
// Ports    :
//   clk_i      - clock, all state changes on the rising edge
//   rst_i      - synchronous active-high reset
//   valid_i    - operation request
//   ready_o    - block can accept a request this cycle (state == IDLE)
//   ALUCtrl_i  - 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL,
//                101 SLL, 110 SRAI, 111 illegal
//   data1_i    - operand A
//   data2_i    - operand B; shift amount is data2_i[SHAMT_W-1:0]
//   flush_i    - abort the in-flight multiply / suppress an accept
//   valid_o    - one-cycle pulse, data_o is valid
//   data_o     - result, held until the next valid_o
//   zero_o     - data_o == 0, qualified by valid_o
//   illegal_o  - pulses with valid_o when the accepted code was 111
// Revision : 1.0 - initial release
// ============================================================================
module iter_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [2:0]         ALUCtrl_i,
    input  logic [WIDTH-1:0]   data1_i,
    input  logic [WIDTH-1:0]   data2_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic               zero_o,
    output logic               illegal_o
);

    // ------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_MUL  = 3'b100;
    localparam logic [2:0] c_OP_SLL  = 3'b101;
    localparam logic [2:0] c_OP_SRAI = 3'b110;
    localparam logic [2:0] c_OP_ILL  = 3'b111;

    // The multiply loop performs exactly WIDTH steps; the step taken while
    // the counter holds WIDTH-1 is the last one.
    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [WIDTH-1:0]     r_data;
    logic                 r_illegal;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [SHAMT_W-1:0]   r_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_mul_step;
    logic                 w_mul_last;
    logic                 w_is_mul;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_alu_res;
    logic [WIDTH-1:0]     w_acc_next;

    assign w_is_mul = (ALUCtrl_i == c_OP_MUL);
    assign w_shamt  = data2_i[SHAMT_W-1:0];

    // Partial-product add for the current multiplier bit.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // ------------------------------------------------------------------
    // Single-cycle result. MUL never uses this path; illegal yields 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_res = '0;
        case (ALUCtrl_i)
            c_OP_ADD:  w_alu_res = data1_i + data2_i;
            c_OP_SUB:  w_alu_res = data1_i - data2_i;
            c_OP_AND:  w_alu_res = data1_i & data2_i;
            c_OP_XOR:  w_alu_res = data1_i ^ data2_i;
            c_OP_SLL:  w_alu_res = data1_i << w_shamt;
            c_OP_SRAI: w_alu_res = WIDTH'($signed(data1_i) >>> w_shamt);
            c_OP_MUL:  w_alu_res = '0;
            c_OP_ILL:  w_alu_res = '0;
            default:   w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_mul_step   = 1'b0;
        w_mul_last   = 1'b0;
        ready_o      = 1'b0;
        valid_o      = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                // A flush in the same cycle as a request cancels the accept.
                if (valid_i && !flush_i) begin
                    w_accept     = 1'b1;
                    w_state_next = w_is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                // Flush wins over completion: the multiply is dropped and
                // data_o keeps the previous result.
                if (flush_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_mul_step = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_mul_last   = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Flush is deliberately ignored here; the pulse always occurs.
                valid_o      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= '0;
            r_illegal <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand   <= data1_i;
                r_mplier  <= data2_i;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_illegal <= 1'b0;
            end else begin
                r_data    <= w_alu_res;
                r_illegal <= (ALUCtrl_i == c_OP_ILL);
            end
        end else if (w_mul_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHAMT_W'(1);
            // Only the low WIDTH bits of the product are kept, so signed
            // and unsigned operands give the same result.
            if (w_mul_last) begin
                r_data <= w_acc_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result outputs
    // ------------------------------------------------------------------
    assign data_o    = r_data;
    assign zero_o    = valid_o & (r_data == '0);
    assign illegal_o = valid_o & r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iter_alu
// Purpose  : Self-checking bench for iter_alu. The driver pushes the
//            expected response (data, zero, illegal, arrival time) into a
//            scoreboard queue at each accept; a monitor pops and compares
//            whenever valid_o is seen, and flags any unexpected pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_alu;

    localparam int  WIDTH  = 32;
    localparam time PERIOD = 10;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] XOR_ = 3'b011;
    localparam logic [2:0] MUL  = 3'b100;
    localparam logic [2:0] SLL  = 3'b101;
    localparam logic [2:0] SRAI = 3'b110;
    localparam logic [2:0] ILL  = 3'b111;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             illegal_o;

    iter_alu #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    initial clk_i = 1'b0;
    always #(PERIOD/2) clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             ill;
        time              t_exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: got data %h at %0t want no pulse",
                                 data_o, $time);
                    end else begin
                        e = sb.pop_front();
                        check("data", data_o, e.data);
                        check("zero", {31'd0, zero_o}, {31'd0, e.zero});
                        check("illegal", {31'd0, illegal_o}, {31'd0, e.ill});
                        check("latency_time", WIDTH'($time), WIDTH'(e.t_exp));
                    end
                end else begin
                    check("flags_idle", {30'd0, zero_o, illegal_o}, 32'd0);
                end
            end
        end
    endtask

    // Issues one request; when exp_on is set the expected response is
    // scoreboarded with its arrival time lat cycles after the accept edge.
    task automatic issue(input logic [2:0] code, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit exp_on,
                         input logic [WIDTH-1:0] res, input bit ill, input int lat);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk_i);
        while (!ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL issue_ready_timeout: got ready 0 want 1");
        end
        valid_i   = 1'b1;
        ALUCtrl_i = code;
        data1_i   = a;
        data2_i   = b;
        @(posedge clk_i);
        if (exp_on) begin
            e.data  = res;
            e.zero  = (res == '0);
            e.ill   = ill;
            e.t_exp = $time + lat * PERIOD - PERIOD/2;
            sb.push_back(e);
        end
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        int guard;
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ALUCtrl_i = 3'b000;
        data1_i   = '0;
        data2_i   = '0;

        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk_i);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_flags", {30'd0, zero_o, illegal_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Basic ops
        issue(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1);
        issue(SUB, 32'd5, 32'd5, 1'b1, 32'h0000_0000, 1'b0, 1);
        @(negedge clk_i);
        check("b2b_ready_low", {31'd0, ready_o}, 32'd0);
        @(negedge clk_i);
        check("b2b_ready_back", {31'd0, ready_o}, 32'd1);
        issue(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1);
        issue(XOR_, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, 32'hA5A5_5A5A, 1'b0, 1);

        // MUL with ready_o low for the whole operation
        issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 33);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk_i);
            check("mul_ready_low", {31'd0, ready_o}, 32'd0);
        end
        issue(MUL, 32'd12345, 32'd678, 1'b1, 32'd8369910, 1'b0, 33);

        // Shifts
        issue(SRAI, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'hF800_0000, 1'b0, 1);
        issue(SLL, 32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000, 1'b0, 1);
        issue(SLL, 32'hDEAD_BEEF, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
        issue(SRAI, 32'h7000_0000, 32'd4, 1'b1, 32'h0700_0000, 1'b0, 1);
        issue(XOR_, 32'hAAAA_5555, 32'h0F0F_0F0F, 1'b1, 32'hA5A5_5A5A, 1'b0, 1);

        // Flush mid-MUL: no pulse, data_o keeps the last result
        issue(MUL, 32'd7, 32'd9, 1'b0, 32'd0, 1'b0, 0);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        check("flush_data_kept", data_o, 32'hA5A5_5A5A);
        repeat (40) @(negedge clk_i);

        // Reset mid-MUL: no pulse, data_o cleared
        issue(MUL, 32'd7, 32'd9, 1'b0, 32'd0, 1'b0, 0);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mul_ready", {31'd0, ready_o}, 32'd1);
        check("rst_mul_data", data_o, 32'd0);
        repeat (40) @(negedge clk_i);

        // Illegal code
        issue(ILL, 32'd5, 32'd6, 1'b1, 32'd0, 1'b1, 1);

        // Flush while idle suppresses the accept
        @(negedge clk_i);
        valid_i   = 1'b1;
        flush_i   = 1'b1;
        ALUCtrl_i = ADD;
        data1_i   = 32'd11;
        data2_i   = 32'd22;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("idle_flush_ready", {31'd0, ready_o}, 32'd1);

        // Flush during DONE has no effect on the pulse
        issue(ADD, 32'd1, 32'd2, 1'b1, 32'd3, 1'b0, 1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;

        // Requests presented during MUL are ignored
        issue(MUL, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, 33);
        valid_i   = 1'b1;
        ALUCtrl_i = ADD;
        data1_i   = 32'd100;
        data2_i   = 32'd200;
        repeat (20) @(negedge clk_i);
        valid_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // Drain
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_valid: got no pulse want data %h", e.data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execution-stage ALU. It consumes the 3-bit ALUCtrl code produced by the ALU control decoder and the two operands, and returns a registered result.
- Single-cycle ops are ADD, SUB, AND, XOR, SLL and SRAI. MUL is executed iteratively by shift-add over WIDTH cycles.
- The pipeline hazard unit uses ready_o and valid_o to stall the pipeline while a MUL is in flight.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount bits taken from data2_i; equals log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- ALUCtrl_i  input  3  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL, 101 SLL, 110 SRAI, 111 illegal.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B; shift amount is data2_i[SHAMT_W-1:0].
- flush_i  input  1  abort the in-flight operation.
- valid_o  output  1  one-cycle pulse: data_o is valid.
- data_o  output  WIDTH  result, held until the next valid_o.
- zero_o  output  1  data_o == 0, qualified by valid_o.
- illegal_o  output  1  pulses with valid_o when the accepted code was 111.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; ready_o=1; valid_o=0; data_o=0; zero_o=0; illegal_o=0; counter=0; accumulator=0.
  - Reset has priority over every other input. Reset during MUL discards the operation with no valid_o.
- Handshake:
  - A request is accepted at an edge where valid_i=1 and ready_o=1; operands and code are captured at that edge.
  - ready_o = (state==IDLE), combinational from state.
  - Inputs are ignored while ready_o=0.
- States: IDLE, MUL, DONE.
- IDLE, accept of a non-MUL code:
  - Compute the result, register it into data_o, go to DONE.
  - valid_o=1 in the cycle after accept (latency 1).
- IDLE, accept of MUL:
  - Load mcand=data1_i, mplier=data2_i, acc=0, counter=0; go to MUL.
- MUL, each cycle:
  - If mplier[0], acc <= acc + mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1 (logical); counter++.
  - When counter reaches WIDTH-1 in this cycle, write the final acc into data_o and go to DONE.
  - valid_o is asserted WIDTH+1 cycles after the accept edge.
  - The result is the low WIDTH bits of the product, so the signed and unsigned low halves are identical.
- DONE:
  - valid_o=1 for exactly one cycle; zero_o=(data_o==0); illegal_o as latched.
  - Next state is IDLE. Back-to-back throughput is one non-MUL op every 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLL is a logical left shift by the shift amount; SRAI is an arithmetic right shift by the shift amount, sign-filled from data1_i[WIDTH-1].
  - A shift amount of 0 passes data1_i through unchanged. Upper bits of data2_i are ignored for shifts.
- Illegal code 111: result 0, illegal_o=1 with valid_o, latency 1.
- flush_i:
  - In MUL, flush_i=1 forces IDLE at the next edge; no valid_o; data_o keeps its previous value.
  - In IDLE with valid_i=1, flush_i=1 suppresses the accept.
  - In DONE, flush_i=1 has no effect; the pulse still occurs.
- valid_i held high after completion starts a new operation whenever ready_o returns high; the block does not deduplicate requests.

Test Plan:
- Reset and basic ops:
  - Stimulus: rst_i=1 for 2 cycles, then ADD 0x7FFFFFFF+1.
  - Response: outputs 0 during reset; valid_o 1 cycle after accept; data_o=0x80000000; zero_o=0.
- SUB and zero flag:
  - SUB 5-5 → data_o=0, zero_o=1.
  - Back-to-back AND 0xF0F0F0F0&0xFF00FF00 → 0xF000F000; ready_o low exactly 1 cycle between ops.
- MUL:
  - 0xFFFFFFFF*0xFFFFFFFF → data_o=0x00000001, valid_o exactly 33 cycles after accept, ready_o=0 throughout.
  - 12345*678 → 8369910.
- Shifts:
  - SRAI 0x80000000 by data2_i=0x00000024 (shamt=4) → 0xF8000000.
  - SLL 0x1 by 31 → 0x80000000.
  - SLL by 0 → data1_i unchanged.
- Flush and reset mid-MUL:
  - Flush at cycle 10 of a MUL → no valid_o, ready_o=1 next cycle, data_o unchanged.
  - Repeat with rst_i instead → data_o=0.
- Illegal code and ignored input:
  - Code 111 → valid_o with illegal_o=1, data_o=0.
  - valid_i during MUL is ignored: its operands never produce a result.
